// File: rtl/receive_packet_ddr.sv
// Receives one TSE Avalon-ST frame per arm command and stores it in DDR as
// 256-bit words: payload at base+1 onward, byte-count word at base written last.
module receive_packet_ddr #(
  parameter int unsigned MAX_BYTES = 255,
  parameter int unsigned ADDR_W    = 25
) (
  input  logic              clk_original,
  input  logic              rst,
  input  logic              cmd_receive,
  input  logic [ADDR_W-1:0] start_ram_addr,
  input  logic [7:0]        ff_rx_data,
  input  logic              ff_rx_dval,
  input  logic              ff_rx_sop,
  input  logic              ff_rx_eop,
  input  logic              ff_rx_err,
  output logic              ff_rx_rdy,
  output logic [ADDR_W-1:0] ram_address,
  output logic [255:0]      ram_data_write,
  output logic              ram_wren,
  input  logic              ram_ready,
  output logic              busy,
  output logic              pkt_done,
  output logic              pkt_drop,
  output logic [10:0]       rx_len
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOP,
    RX,
    DISCARD,
    FLUSH,
    WRITE_LEN,
    DROP
  } state_t;

  localparam logic [10:0] MAX_CNT = 11'(MAX_BYTES);

  state_t            state;
  logic [ADDR_W-1:0] base_addr;
  logic [10:0]       cnt;
  logic [255:0]      asm_reg;
  logic [255:0]      asm_next;
  logic              hold_valid;
  logic              beat;
  logic              store;
  logic              push;
  logic [4:0]        k;
  logic [7:0]        lsb;
  logic [ADDR_W-1:0] word_addr;

  assign beat      = ff_rx_dval & ff_rx_rdy;
  assign k         = cnt[4:0];
  // Big-endian within each 32-bit lane: byte k lands at lane k/4, slot 3-k%4.
  assign lsb       = {k[4:2], ~k[1:0], 3'b000};
  assign word_addr = base_addr + ADDR_W'(cnt[10:5]) + ADDR_W'(1);

  assign ram_wren  = hold_valid;
  assign busy      = (state != IDLE);
  assign ff_rx_rdy = (state == WAIT_SOP) | ((state == RX) & ~hold_valid) |
                     (state == DISCARD);

  always_comb begin
    asm_next           = asm_reg;
    asm_next[lsb +: 8] = ff_rx_data;
  end

  always_comb begin
    store = 1'b0;
    push  = 1'b0;
    case (state)
      WAIT_SOP: begin
        store = beat & ff_rx_sop;
        push  = beat & ff_rx_sop & ff_rx_eop;
      end
      RX: begin
        store = beat & ~ff_rx_sop & (cnt != MAX_CNT);
        push  = beat & ~ff_rx_sop & (cnt != MAX_CNT) & (ff_rx_eop | (k == 5'd31));
      end
      default: begin
        store = 1'b0;
        push  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_original or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      base_addr      <= '0;
      cnt            <= '0;
      asm_reg        <= '0;
      hold_valid     <= 1'b0;
      ram_address    <= '0;
      ram_data_write <= '0;
      pkt_done       <= 1'b0;
      pkt_drop       <= 1'b0;
      rx_len         <= '0;
    end else begin
      pkt_done <= 1'b0;
      pkt_drop <= 1'b0;

      if (hold_valid && ram_ready)
        hold_valid <= 1'b0;

      // A completed word is only pushed while the hold register is empty,
      // so the load below never overwrites a pending write.
      if (store) begin
        cnt <= cnt + 11'd1;
        if (push) begin
          ram_data_write <= asm_next;
          ram_address    <= word_addr;
          hold_valid     <= 1'b1;
          asm_reg        <= '0;
        end else begin
          asm_reg <= asm_next;
        end
      end

      case (state)
        IDLE: begin
          if (cmd_receive) begin
            base_addr <= start_ram_addr;
            cnt       <= '0;
            asm_reg   <= '0;
            state     <= WAIT_SOP;
          end
        end
        WAIT_SOP: begin
          if (beat && ff_rx_sop) begin
            if (ff_rx_eop)
              state <= ff_rx_err ? DROP : FLUSH;
            else
              state <= RX;
          end
        end
        RX: begin
          if (beat) begin
            if (ff_rx_sop || cnt == MAX_CNT)
              state <= ff_rx_eop ? DROP : DISCARD;
            else if (ff_rx_eop)
              state <= ff_rx_err ? DROP : FLUSH;
          end
        end
        DISCARD: begin
          if (beat && ff_rx_eop)
            state <= DROP;
        end
        FLUSH: begin
          if (!hold_valid) begin
            ram_data_write <= 256'(cnt);
            ram_address    <= base_addr;
            hold_valid     <= 1'b1;
            state          <= WRITE_LEN;
          end
        end
        // The done/drop pulse is issued while still outside IDLE so an arm
        // arriving in the same cycle is ignored.
        WRITE_LEN: begin
          if (pkt_done) begin
            state <= IDLE;
          end else if (hold_valid && ram_ready) begin
            rx_len   <= cnt;
            pkt_done <= 1'b1;
          end
        end
        DROP: begin
          if (pkt_drop)
            state <= IDLE;
          else if (!hold_valid)
            pkt_drop <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_receive_packet_ddr.sv
// Directed bench for receive_packet_ddr: a byte-level model predicts every DDR
// write; a negedge monitor compares writes, write stability and pulse counts.
module tb_receive_packet_ddr;

  localparam int unsigned AW = 25;

  logic          clk_original = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_receive = 1'b0;
  logic [AW-1:0] start_ram_addr = '0;
  logic [7:0]    ff_rx_data = '0;
  logic          ff_rx_dval = 1'b0;
  logic          ff_rx_sop = 1'b0;
  logic          ff_rx_eop = 1'b0;
  logic          ff_rx_err = 1'b0;
  logic          ff_rx_rdy;
  logic [AW-1:0] ram_address;
  logic [255:0]  ram_data_write;
  logic          ram_wren;
  logic          ram_ready = 1'b1;
  logic          busy;
  logic          pkt_done;
  logic          pkt_drop;
  logic [10:0]   rx_len;

  receive_packet_ddr #(.MAX_BYTES(255), .ADDR_W(AW)) dut (
    .clk_original   (clk_original),
    .rst            (rst),
    .cmd_receive    (cmd_receive),
    .start_ram_addr (start_ram_addr),
    .ff_rx_data     (ff_rx_data),
    .ff_rx_dval     (ff_rx_dval),
    .ff_rx_sop      (ff_rx_sop),
    .ff_rx_eop      (ff_rx_eop),
    .ff_rx_err      (ff_rx_err),
    .ff_rx_rdy      (ff_rx_rdy),
    .ram_address    (ram_address),
    .ram_data_write (ram_data_write),
    .ram_wren       (ram_wren),
    .ram_ready      (ram_ready),
    .busy           (busy),
    .pkt_done       (pkt_done),
    .pkt_drop       (pkt_drop),
    .rx_len         (rx_len)
  );

  always #5 clk_original = ~clk_original;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  int unsigned   done_cnt = 0;
  int unsigned   drop_cnt = 0;
  int unsigned   log_n = 0;
  logic [AW-1:0] log_addr [64];
  logic [255:0]  log_data [64];
  logic [7:0]    tx_bytes [512];
  logic [AW-1:0] exp_addr [$];
  logic [255:0]  exp_data [$];
  bit            drop_mode = 1'b0;
  logic [AW-1:0] drop_base = '0;
  bit            prev_wait = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [255:0]  prev_data = '0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: layout of stored frame, derived from byte index arithmetic.
  task automatic expect_frame(input logic [AW-1:0] base, input int unsigned n);
    int unsigned nwords = (n + 31) / 32;
    for (int unsigned w = 0; w < nwords; w++) begin
      logic [255:0] d = '0;
      for (int unsigned j = w * 32; j < n && j < w * 32 + 32; j++) begin
        int unsigned kk = j % 32;
        d[(kk / 4) * 32 + 31 - 8 * (kk % 4) -: 8] = tx_bytes[j];
      end
      exp_addr.push_back(base + AW'(1 + w));
      exp_data.push_back(d);
    end
    exp_addr.push_back(base);
    exp_data.push_back(256'(n));
  endtask

  always @(negedge clk_original) begin
    if (rst) begin
      prev_wait = 1'b0;
    end else begin
      if (prev_wait) begin
        chk("stall_wren", ram_wren, 1);
        chk("stall_addr", ram_address, prev_addr);
        chk("stall_data", ram_data_write, prev_data);
      end
      if (ram_wren && ram_ready) begin
        if (log_n < 64) begin
          log_addr[log_n] = ram_address;
          log_data[log_n] = ram_data_write;
        end
        log_n++;
        if (exp_addr.size() > 0) begin
          chk("wr_addr", ram_address, exp_addr.pop_front());
          chk("wr_data", ram_data_write, exp_data.pop_front());
        end else if (drop_mode) begin
          checks++;
          if (ram_address <= drop_base || ram_address > drop_base + AW'(8)) begin
            errors++;
            $display("FAIL drop_write_addr: got %0h, required within base+1..base+8 of %0h",
                     ram_address, drop_base);
          end
        end else begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0h data %0h, required no write",
                   ram_address, ram_data_write);
        end
      end
      prev_wait = ram_wren && !ram_ready;
      prev_addr = ram_address;
      prev_data = ram_data_write;
      if (pkt_done) done_cnt++;
      if (pkt_drop) drop_cnt++;
    end
  end

  task automatic step;
    @(posedge clk_original);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic s, input logic e, input logic er);
    int unsigned t = 0;
    bit acc = 1'b0;
    ff_rx_data = d; ff_rx_sop = s; ff_rx_eop = e; ff_rx_err = er; ff_rx_dval = 1'b1;
    while (!acc && t < 200) begin
      @(negedge clk_original);
      acc = ff_rx_rdy;
      step();
      t++;
    end
    ff_rx_dval = 1'b0; ff_rx_sop = 1'b0; ff_rx_eop = 1'b0; ff_rx_err = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: byte %0h not accepted, required acceptance within 200 cycles", d);
    end
  endtask

  task automatic send_frame(input int unsigned n, input bit er, input bit with_eop);
    for (int unsigned i = 0; i < n; i++)
      send_beat(tx_bytes[i], i == 0, with_eop && (i == n - 1), er && (i == n - 1));
  endtask

  task automatic arm(input logic [AW-1:0] base);
    int unsigned t = 0;
    while (busy && t < 200) begin step(); t++; end
    chk("arm_idle", busy, 0);
    start_ram_addr = base;
    cmd_receive = 1'b1;
    step();
    cmd_receive = 1'b0;
    chk("arm_busy", busy, 1);
  endtask

  task automatic wait_counts(input int unsigned dn, input int unsigned dr);
    int unsigned t = 0;
    while ((done_cnt < dn || drop_cnt < dr) && t < 300) begin step(); t++; end
    repeat (4) step();
    chk("done_count", done_cnt, dn);
    chk("drop_count", drop_cnt, dr);
    chk("busy_after", busy, 0);
  endtask

  int unsigned s;

  initial begin
    #12;
    chk("rst_rdy", ff_rx_rdy, 0);
    chk("rst_wren", ram_wren, 0);
    chk("rst_addr", ram_address, 0);
    chk("rst_data", ram_data_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_drop", {pkt_done, pkt_drop}, 0);
    chk("rst_len", rx_len, 0);
    step();
    rst = 1'b0;
    repeat (2) step();

    // 1: 40-byte frame
    for (int i = 0; i < 40; i++) tx_bytes[i] = 8'(i);
    s = log_n;
    expect_frame(25'h100, 40);
    arm(25'h100);
    send_frame(40, 1'b0, 1'b1);
    wait_counts(1, 0);
    chk("t1_len", rx_len, 40);
    chk("t1_q_empty", exp_addr.size(), 0);
    chk("t1_a0", log_addr[s], 25'h101);
    chk("t1_b0", log_data[s][31:24], 8'h00);
    chk("t1_b3", log_data[s][7:0], 8'h03);
    chk("t1_b4", log_data[s][63:56], 8'h04);
    chk("t1_a1", log_addr[s+1], 25'h102);
    chk("t1_b32", log_data[s+1][31:24], 8'h20);
    chk("t1_hi_zero", log_data[s+1][255:64], 0);
    chk("t1_a2", log_addr[s+2], 25'h100);
    chk("t1_lenword", log_data[s+2], 256'd40);

    // 2: single-beat frame
    tx_bytes[0] = 8'hA5;
    s = log_n;
    expect_frame(25'h200, 1);
    arm(25'h200);
    send_frame(1, 1'b0, 1'b1);
    wait_counts(2, 0);
    chk("t2_word", log_data[s], 256'hA500_0000);
    chk("t2_lenword", log_data[s+1], 256'd1);
    chk("t2_len", rx_len, 1);

    // 3: 64-byte frame, first write stalled 10 cycles
    for (int i = 0; i < 64; i++) tx_bytes[i] = 8'(i * 3 + 1);
    expect_frame(25'h300, 64);
    arm(25'h300);
    ram_ready = 1'b0;
    fork
      send_frame(64, 1'b0, 1'b1);
      begin
        int unsigned t = 0;
        while (!ram_wren && t < 500) begin step(); t++; end
        chk("t3_stall_seen", ram_wren, 1);
        repeat (10) begin
          @(negedge clk_original);
          chk("t3_rdy_low", ff_rx_rdy, 0);
        end
        step();
        ram_ready = 1'b1;
      end
    join
    wait_counts(3, 0);
    chk("t3_len", rx_len, 64);
    chk("t3_q_empty", exp_addr.size(), 0);

    // 4: oversize frame
    for (int i = 0; i < 300; i++) tx_bytes[i] = 8'(i + 7);
    drop_mode = 1'b1; drop_base = 25'h400;
    arm(25'h400);
    send_frame(300, 1'b0, 1'b1);
    wait_counts(3, 1);
    chk("t4_len_kept", rx_len, 64);

    // 5: errored frame, then a good one
    for (int i = 0; i < 20; i++) tx_bytes[i] = 8'(8'hF0 - i);
    drop_base = 25'h500;
    arm(25'h500);
    send_frame(20, 1'b1, 1'b1);
    wait_counts(3, 2);
    chk("t5_len_kept", rx_len, 64);
    drop_mode = 1'b0;
    for (int i = 0; i < 10; i++) tx_bytes[i] = 8'(8'h50 + i);
    expect_frame(25'h600, 10);
    arm(25'h600);
    send_frame(10, 1'b0, 1'b1);
    wait_counts(4, 2);
    chk("t5_len", rx_len, 10);

    // 6: stray beats, then reset mid-frame with a pending write
    s = log_n;
    arm(25'h700);
    for (int i = 0; i < 3; i++) send_beat(8'(8'hE0 + i), 1'b0, 1'b0, 1'b0);
    chk("t6_stray_nowrite", log_n, s);
    chk("t6_stray_busy", busy, 1);
    for (int i = 0; i < 32; i++) tx_bytes[i] = 8'(i + 8'h80);
    ram_ready = 1'b0;
    send_frame(32, 1'b0, 1'b0);
    chk("t6_pending", ram_wren, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_wren", ram_wren, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_rdy", ff_rx_rdy, 0);
    chk("t6_rst_addr", ram_address, 0);
    chk("t6_rst_len", rx_len, 0);
    repeat (2) step();
    #3 rst = 1'b0;
    ram_ready = 1'b1;
    ff_rx_dval = 1'b1; ff_rx_sop = 1'b1; ff_rx_data = 8'h11;
    repeat (5) begin
      @(negedge clk_original);
      chk("t6_unarmed_rdy", ff_rx_rdy, 0);
      chk("t6_unarmed_busy", busy, 0);
    end
    step();
    ff_rx_dval = 1'b0; ff_rx_sop = 1'b0;
    chk("t6_no_writes", log_n, s);
    for (int i = 0; i < 5; i++) tx_bytes[i] = 8'(8'hC0 + i);
    expect_frame(25'h800, 5);
    arm(25'h800);
    send_frame(5, 1'b0, 1'b1);
    wait_counts(5, 2);
    chk("t6_len", rx_len, 5);
    chk("t6_q_empty", exp_addr.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
